// File: rtl/hsi2rgb_if.sv
// Pixel stream bundle for the HSI888 -> RGB888 converter: HSI side in, RGB side out.
interface hsi2rgb_if;
  logic        HSI_hsync;
  logic        HSI_vsync;
  logic [7:0]  H_data;
  logic [7:0]  S_data;
  logic [7:0]  I_data;
  logic        HSI_de;
  logic        RGB_hsync;
  logic        RGB_vsync;
  logic [23:0] RGB_data;
  logic        RGB_de;

  modport master (
    output HSI_hsync, HSI_vsync, H_data, S_data, I_data, HSI_de,
    input  RGB_hsync, RGB_vsync, RGB_data, RGB_de
  );

  modport slave (
    input  HSI_hsync, HSI_vsync, H_data, S_data, I_data, HSI_de,
    output RGB_hsync, RGB_vsync, RGB_data, RGB_de
  );
endinterface

// File: rtl/hsi2rgb.sv
// HSI888 -> RGB888 converter: 4-stage fixed-latency pipeline, one pixel per clock,
// syncs and de delayed alongside the pixel data.
module hsi2rgb #(
  parameter int unsigned H_DISP = 640,
  parameter int unsigned V_DISP = 480
) (
  input  logic      clk,
  input  logic      rst,
  hsi2rgb_if.slave  bus
);

  localparam int unsigned HUE_WRAP = 240;
  localparam int unsigned SEC_LEN  = 80;
  localparam int unsigned DLY      = 4;
  localparam int unsigned KW       = 11;
  localparam int unsigned PW       = 27;
  localparam int unsigned VW       = 12;

  // Geometry is carried only for hierarchy consistency; reject nonsense at elaboration.
  if (H_DISP == 0 || V_DISP == 0) begin : g_bad_geometry
    $error("hsi2rgb: H_DISP and V_DISP must be non-zero");
  end

  logic [DLY-1:0]       hs_q, vs_q, de_q;
  logic [1:0]           s1_sec, s2_sec, s3_sec;
  logic [6:0]           s1_h;
  logic [7:0]           s1_s, s1_i, s2_s, s2_i, s3_i, s3_x;
  logic signed [KW-1:0] s2_k;
  logic signed [VW-1:0] s3_y;
  logic [23:0]          rgb_q;

  logic [7:0]           hw_c;
  logic [1:0]           sec_c;
  logic [6:0]           h_c;
  logic signed [KW-1:0] k_c;
  logic [15:0]          xp_c;
  logic [7:0]           x_c;
  logic signed [PW-1:0] i_w, s_w, k_w, p_c;
  logic signed [VW-1:0] y_c, z_c;
  logic [7:0]           cy_c, cz_c;
  logic [23:0]          rgb_c;

  function automatic logic [7:0] clamp8(input logic signed [VW-1:0] v);
    if (v < 12'sd0)   return 8'd0;
    if (v > 12'sd255) return 8'hFF;
    return v[7:0];
  endfunction

  // Stage 1: fold hue into 0..239, then split into sector and offset within the sector.
  always_comb begin
    hw_c  = (bus.H_data >= 8'(HUE_WRAP)) ? bus.H_data - 8'(HUE_WRAP) : bus.H_data;
    sec_c = 2'd0;
    h_c   = 7'(hw_c);
    if (hw_c >= 8'(2 * SEC_LEN)) begin
      sec_c = 2'd2;
      h_c   = 7'(hw_c - 8'(2 * SEC_LEN));
    end else if (hw_c >= 8'(SEC_LEN)) begin
      sec_c = 2'd1;
      h_c   = 7'(hw_c - 8'(SEC_LEN));
    end
  end

  // K(h) = round(256*cos(1.5h deg)/cos(60-1.5h deg)), h = 0..79
  always_comb begin
    k_c = '0;
    case (s1_h)
      7'd0:  k_c = 11'sd512;  7'd1:  k_c = 11'sd490;  7'd2:  k_c = 11'sd469;  7'd3:  k_c = 11'sd451;
      7'd4:  k_c = 11'sd433;  7'd5:  k_c = 11'sd417;  7'd6:  k_c = 11'sd402;  7'd7:  k_c = 11'sd388;
      7'd8:  k_c = 11'sd374;  7'd9:  k_c = 11'sd362;  7'd10: k_c = 11'sd350;  7'd11: k_c = 11'sd338;
      7'd12: k_c = 11'sd328;  7'd13: k_c = 11'sd317;  7'd14: k_c = 11'sd308;  7'd15: k_c = 11'sd298;
      7'd16: k_c = 11'sd289;  7'd17: k_c = 11'sd280;  7'd18: k_c = 11'sd272;  7'd19: k_c = 11'sd264;
      7'd20: k_c = 11'sd256;  7'd21: k_c = 11'sd248;  7'd22: k_c = 11'sd241;  7'd23: k_c = 11'sd234;
      7'd24: k_c = 11'sd227;  7'd25: k_c = 11'sd220;  7'd26: k_c = 11'sd213;  7'd27: k_c = 11'sd207;
      7'd28: k_c = 11'sd200;  7'd29: k_c = 11'sd194;  7'd30: k_c = 11'sd187;  7'd31: k_c = 11'sd181;
      7'd32: k_c = 11'sd175;  7'd33: k_c = 11'sd169;  7'd34: k_c = 11'sd163;  7'd35: k_c = 11'sd157;
      7'd36: k_c = 11'sd151;  7'd37: k_c = 11'sd145;  7'd38: k_c = 11'sd140;  7'd39: k_c = 11'sd134;
      7'd40: k_c = 11'sd128;  7'd41: k_c = 11'sd122;  7'd42: k_c = 11'sd116;  7'd43: k_c = 11'sd111;
      7'd44: k_c = 11'sd105;  7'd45: k_c = 11'sd99;   7'd46: k_c = 11'sd93;   7'd47: k_c = 11'sd87;
      7'd48: k_c = 11'sd81;   7'd49: k_c = 11'sd75;   7'd50: k_c = 11'sd69;   7'd51: k_c = 11'sd62;
      7'd52: k_c = 11'sd56;   7'd53: k_c = 11'sd49;   7'd54: k_c = 11'sd43;   7'd55: k_c = 11'sd36;
      7'd56: k_c = 11'sd29;   7'd57: k_c = 11'sd22;   7'd58: k_c = 11'sd15;   7'd59: k_c = 11'sd8;
      7'd60: k_c = 11'sd0;    7'd61: k_c = -11'sd8;   7'd62: k_c = -11'sd16;  7'd63: k_c = -11'sd24;
      7'd64: k_c = -11'sd33;  7'd65: k_c = -11'sd42;  7'd66: k_c = -11'sd52;  7'd67: k_c = -11'sd61;
      7'd68: k_c = -11'sd72;  7'd69: k_c = -11'sd82;  7'd70: k_c = -11'sd94;  7'd71: k_c = -11'sd106;
      7'd72: k_c = -11'sd118; 7'd73: k_c = -11'sd132; 7'd74: k_c = -11'sd146; 7'd75: k_c = -11'sd161;
      7'd76: k_c = -11'sd177; 7'd77: k_c = -11'sd195; 7'd78: k_c = -11'sd213; 7'd79: k_c = -11'sd234;
      default: k_c = '0;
    endcase
  end

  // Stage 3: x = I(1-S), y = I + I*S*K/65536 with floor on the signed product.
  always_comb begin
    xp_c = 16'(s2_i) * (16'd256 - 16'(s2_s));
    x_c  = 8'(xp_c >> 8);
    i_w  = PW'(s2_i);
    s_w  = PW'(s2_s);
    k_w  = PW'(s2_k);
    p_c  = i_w * s_w * k_w;
    y_c  = VW'(s2_i) + VW'(p_c >>> 16);
  end

  // Stage 4: third component, clamping, sector rotation and blanking.
  always_comb begin
    z_c   = VW'(s3_i) * 12'd3 - VW'(s3_x) - s3_y;
    cy_c  = clamp8(s3_y);
    cz_c  = clamp8(z_c);
    case (s3_sec)
      2'd0:    rgb_c = {cy_c, cz_c, s3_x};
      2'd1:    rgb_c = {s3_x, cy_c, cz_c};
      default: rgb_c = {cz_c, s3_x, cy_c};
    endcase
    if (!de_q[2]) rgb_c = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_q   <= '0;
      vs_q   <= '0;
      de_q   <= '0;
      s1_sec <= '0;
      s1_h   <= '0;
      s1_s   <= '0;
      s1_i   <= '0;
      s2_sec <= '0;
      s2_k   <= '0;
      s2_s   <= '0;
      s2_i   <= '0;
      s3_sec <= '0;
      s3_i   <= '0;
      s3_x   <= '0;
      s3_y   <= '0;
      rgb_q  <= '0;
    end else begin
      hs_q   <= {hs_q[DLY-2:0], bus.HSI_hsync};
      vs_q   <= {vs_q[DLY-2:0], bus.HSI_vsync};
      de_q   <= {de_q[DLY-2:0], bus.HSI_de};
      s1_sec <= sec_c;
      s1_h   <= h_c;
      s1_s   <= bus.S_data;
      s1_i   <= bus.I_data;
      s2_sec <= s1_sec;
      s2_k   <= k_c;
      s2_s   <= s1_s;
      s2_i   <= s1_i;
      s3_sec <= s2_sec;
      s3_i   <= s2_i;
      s3_x   <= x_c;
      s3_y   <= y_c;
      rgb_q  <= rgb_c;
    end
  end

  assign bus.RGB_hsync = hs_q[DLY-1];
  assign bus.RGB_vsync = vs_q[DLY-1];
  assign bus.RGB_de    = de_q[DLY-1];
  assign bus.RGB_data  = rgb_q;

endmodule

// File: tb/tb_hsi2rgb.sv
// Bench for hsi2rgb: directed vectors plus randomized pixels scored against a
// floating-point derived reference of the HSI -> RGB conversion.
module tb_hsi2rgb;

  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hsi2rgb_if bus();

  hsi2rgb #(.H_DISP(640), .V_DISP(480)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [26:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int k_of(input int h);
    real a, r;
    a = 1.5 * h * PI / 180.0;
    r = 256.0 * $cos(a) / $cos(PI / 3.0 - a);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
  endfunction

  function automatic int clamp255(input int v);
    return (v < 0) ? 0 : (v > 255) ? 255 : v;
  endfunction

  function automatic int floor_div(input longint n, input longint d);
    longint q;
    q = n / d;
    if ((n % d != 0) && (n < 0)) q = q - 1;
    return int'(q);
  endfunction

  // Reference conversion straight from the HSI sector formulas.
  function automatic logic [23:0] ref_rgb(input int hh, input int ss, input int ii);
    int hw, sec, h, x, y, z, cy, cz;
    longint p;
    hw  = (hh >= 240) ? hh - 240 : hh;
    sec = hw / 80;
    h   = hw % 80;
    x   = ii * (256 - ss) / 256;
    p   = longint'(ii) * longint'(ss) * longint'(k_of(h));
    y   = ii + floor_div(p, 65536);
    z   = 3 * ii - x - y;
    cy  = clamp255(y);
    cz  = clamp255(z);
    case (sec)
      0:       return {8'(cy), 8'(cz), 8'(x)};
      1:       return {8'(x), 8'(cy), 8'(cz)};
      default: return {8'(cz), 8'(x), 8'(cy)};
    endcase
  endfunction

  function automatic logic [31:0] observed();
    return 32'({bus.RGB_hsync, bus.RGB_vsync, bus.RGB_de, bus.RGB_data});
  endfunction

  task automatic prefill();
    exp_q.delete();
    repeat (4) exp_q.push_back(27'h0);
  endtask

  // One clock: score the pixel leaving the pipe, then present the next one.
  task automatic cyc(input int hh, input int ss, input int ii, input logic de, input logic hs, input logic vs);
    logic [26:0] exp;
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    check_eq("pipe", observed(), 32'(exp));
    bus.H_data    = 8'(hh);
    bus.S_data    = 8'(ss);
    bus.I_data    = 8'(ii);
    bus.HSI_de    = de;
    bus.HSI_hsync = hs;
    bus.HSI_vsync = vs;
    exp_q.push_back({hs, vs, de, de ? ref_rgb(hh, ss, ii) : 24'h0});
  endtask

  task automatic idle();
    cyc(0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic directed(input string tag, input int hh, input int ss, input int ii, input logic [23:0] exp);
    cyc(hh, ss, ii, 1'b1, 1'b0, 1'b0);
    repeat (4) idle();
    check_eq(tag, 32'(bus.RGB_data), 32'(exp));
    check_eq({tag, "_de"}, 32'(bus.RGB_de), 32'd1);
  endtask

  initial begin
    bus.H_data = '0; bus.S_data = '0; bus.I_data = '0;
    bus.HSI_de = 1'b0; bus.HSI_hsync = 1'b0; bus.HSI_vsync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_state", observed(), 32'h0);
    rst = 1'b0;
    prefill();

    directed("t1_h0", 0, 255, 85, 24'hFE0100);
    directed("t2_h40", 40, 128, 100, 24'h7D7D32);
    directed("t2_h120", 120, 128, 100, 24'h327D7D);
    directed("t2_h200", 200, 128, 100, 24'h7D327D);
    directed("h240_eq_h0", 240, 255, 85, 24'hFE0100);
    directed("grey_h0", 0, 0, 100, 24'h646464);
    directed("grey_h240", 240, 0, 100, 24'h646464);
    directed("grey_h255", 255, 0, 100, 24'h646464);
    directed("black_i0", 37, 200, 0, 24'h000000);

    // Grey sweep over every hue code, back to back.
    for (int h = 0; h < 256; h++) cyc(h, 0, 100, 1'b1, 1'b0, 1'b0);
    // Hue sweep with random S/I, crossing every sector edge and the wrap.
    for (int h = 0; h < 256; h++) cyc(h, $urandom_range(255), $urandom_range(255), 1'b1, 1'b0, 1'b0);
    cyc(79, 200, 150, 1'b1, 1'b0, 1'b0);
    cyc(80, 200, 150, 1'b1, 1'b0, 1'b0);
    cyc(159, 200, 150, 1'b1, 1'b0, 1'b0);
    cyc(160, 200, 150, 1'b1, 1'b0, 1'b0);

    // Reduced frame with sync pulses and blanking carrying random junk data.
    for (int ln = 0; ln < 8; ln++) begin
      for (int px = 0; px < 60; px++) begin
        cyc($urandom_range(255), $urandom_range(255), $urandom_range(255),
            (ln >= 2) && (px >= 10) && (px < 58), px < 6, ln < 2);
      end
    end

    // de toggling every clock.
    for (int n = 0; n < 200; n++)
      cyc($urandom_range(255), $urandom_range(255), $urandom_range(255), n[0], 1'b0, 1'b0);

    // Reset mid-line with four live pixels in flight.
    for (int n = 0; n < 4; n++)
      cyc(20 + 60 * n, 180, 200, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check_eq("pre_rst", observed(), 32'(exp_q.pop_front()));
    rst = 1'b1;
    bus.H_data = '0; bus.S_data = '0; bus.I_data = '0;
    bus.HSI_de = 1'b0; bus.HSI_hsync = 1'b0; bus.HSI_vsync = 1'b0;
    #1;
    check_eq("rst_async", observed(), 32'h0);
    @(posedge clk);
    #1;
    check_eq("rst_hold", observed(), 32'h0);
    rst = 1'b0;
    prefill();
    directed("post_rst", 40, 128, 100, 24'h7D7D32);

    // Long randomized run.
    for (int n = 0; n < 1500; n++)
      cyc($urandom_range(255), $urandom_range(255), $urandom_range(255),
          $urandom_range(7) != 0, 1'($urandom_range(1)), 1'($urandom_range(1)));

    repeat (4) idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
